// File: rtl/serial_addsub_sequencer.sv
// Bit-serial add/sub sequencer: drives one full-adder cell LSB first.
// Ports: clk, rst_n, start/sub/a/b in; busy, done, result, cout, ovf out.
// SERIAL_ADDSUB_OVF_EN: enables the signed-overflow register (ovf=0 otherwise).
module serial_addsub_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    bit_cnt;
  logic             carry;
  logic             cout_q;
  logic             s;
  logic             co;
  logic             last;
  logic             accept;

  // The shared full-adder cell
  assign s  = a_sh[0] ^ b_sh[0] ^ carry;
  assign co = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

  assign last   = (bit_cnt == CW'(WIDTH-1));
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      bit_cnt  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      // Subtract as a + ~b + 1
      a_sh    <= a;
      b_sh    <= sub ? ~b : b;
      carry   <= sub;
      res_sh  <= '0;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      res_sh  <= {s, res_sh[WIDTH-1:1]};
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry   <= co;
      bit_cnt <= bit_cnt + CW'(1);
      if (last) begin
        result_q <= {s, res_sh[WIDTH-1:1]};
        cout_q   <= co;
      end
    end
  end

  assign result = result_q;
  assign cout   = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic c_msb;
  logic ovf_q;

  // c_msb keeps the carry into the MSB for the overflow check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == RUN) begin
      if (bit_cnt == CW'(WIDTH-2)) c_msb <= co;
      if (last) ovf_q <= c_msb ^ co;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_sequencer.sv
// Directed self-checking bench for serial_addsub_sequencer (WIDTH=8).
// Uses immediate assertions; prints a passed/total summary.
module tb_serial_addsub_sequencer;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  int total  = 0;
  int passed = 0;

  serial_addsub_sequencer #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {ovf, cout, result}
  function automatic logic [9:0] model(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic s);
    logic [8:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, (s ? ~y : y)} + {8'b0, s};
    if (s) v = (x[7] != y[7]) && (t[7] != x[7]);
    else   v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v & OVF_EN, t};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ta,
                        input logic [7:0] tb, input logic ts,
                        input logic [7:0] er, input logic ec,
                        input logic eo);
    int n;
    int bn;
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = ~ts;
    bn = busy ? 1 : 0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy) bn++;
    end
    chk({tag, " latency"}, 32'(n), 32'd8);
    chk({tag, " busy_cycles"}, 32'(bn), 32'd8);
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk); #1;
    chk({tag, " done_clear"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp [3];
    logic [9:0] m;
    int dn;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst busy", 32'(busy), 32'd0);
    chk("post_rst done", 32'(done), 32'd0);
    chk("post_rst result", 32'(result), 32'd0);

    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub_5_3", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op("sub_3_5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_EN);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, OVF_EN);

    // Start held high, operands changing every cycle
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      a = 8'(k * 37 + 5);
      b = 8'(k * 11 + 200);
      sub = ((k / 10) % 2) == 1;
      start = 1'b1;
      if (k % 10 == 0) exp[k / 10] = model(a, b, sub);
      @(posedge clk); #1;
      if (k % 10 == 8) begin
        m = exp[k / 10];
        chk($sformatf("hold%0d done", k / 10), 32'(done), 32'd1);
        chk($sformatf("hold%0d result", k / 10), 32'(result), 32'(m[7:0]));
        chk($sformatf("hold%0d cout", k / 10), 32'(cout), 32'(m[8]));
        chk($sformatf("hold%0d ovf", k / 10), 32'(ovf), 32'(m[9]));
      end else begin
        chk($sformatf("hold k%0d no_done", k), 32'(done), 32'd0);
      end
      if (k >= 10 && k % 10 == 5) begin
        m = exp[k / 10 - 1];
        chk($sformatf("hold k%0d stable", k), 32'(result), 32'(m[7:0]));
      end
    end
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a run
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst cout", 32'(cout), 32'd0);
    chk("midrst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("midrst no_done", 32'(dn), 32'd0);
    run_op("add_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
